// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Brief    : RV32 multicycle sequencer: decode, memory wait, branch resolve
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_fsm #(
    parameter int MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7b5,
    input  logic       Zero,
    input  logic       Negative,
    input  logic       Carry,
    input  logic       Overflow,
    input  logic       MemReady,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_XOR  = 3'b100;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_SLTU = 3'b110;
    localparam logic [2:0] c_ALU_PASS = 3'b111;

    localparam logic [1:0] c_SRCA_PC    = 2'd0;
    localparam logic [1:0] c_SRCA_OLDPC = 2'd1;
    localparam logic [1:0] c_SRCA_REG   = 2'd2;
    localparam logic [1:0] c_SRCB_WDATA = 2'd0;
    localparam logic [1:0] c_SRCB_IMM   = 2'd1;
    localparam logic [1:0] c_SRCB_FOUR  = 2'd2;
    localparam logic [1:0] c_RES_ALUOUT = 2'd0;
    localparam logic [1:0] c_RES_DATA   = 2'd1;
    localparam logic [1:0] c_RES_ALURES = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_mem_ready;
    logic       w_is_store;
    logic       w_func_legal;
    logic [2:0] w_func_alu;
    logic       w_r_legal;
    logic [2:0] w_r_alu;
    logic       w_lt;
    logic       w_branch_taken;
    logic       w_branch_legal;

    assign w_mem_ready = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;
    assign w_is_store  = (op == c_OP_STORE);

    // Shared func3 map for register and immediate ALU ops; shifts are unsupported.
    always_comb begin
        w_func_alu   = c_ALU_ADD;
        w_func_legal = 1'b1;
        case (func3)
            3'b000:  w_func_alu = c_ALU_ADD;
            3'b111:  w_func_alu = c_ALU_AND;
            3'b110:  w_func_alu = c_ALU_OR;
            3'b100:  w_func_alu = c_ALU_XOR;
            3'b010:  w_func_alu = c_ALU_SLT;
            3'b011:  w_func_alu = c_ALU_SLTU;
            default: w_func_legal = 1'b0;
        endcase
    end

    assign w_r_legal = w_func_legal && (!func7b5 || (func3 == 3'b000));
    assign w_r_alu   = (func7b5 && (func3 == 3'b000)) ? c_ALU_SUB : w_func_alu;

    // Carry is the no-borrow flag of A-B, so unsigned less-than is !Carry.
    assign w_lt = Negative ^ Overflow;

    always_comb begin
        w_branch_taken = 1'b0;
        w_branch_legal = 1'b1;
        case (func3)
            3'b000:  w_branch_taken = Zero;
            3'b001:  w_branch_taken = !Zero;
            3'b100:  w_branch_taken = w_lt;
            3'b101:  w_branch_taken = !w_lt;
            3'b110:  w_branch_taken = !Carry;
            3'b111:  w_branch_taken = Carry;
            default: w_branch_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        RegWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        MemWrite     = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = c_RES_ALUOUT;
        ALUSrcA      = c_SRCA_PC;
        ALUSrcB      = c_SRCB_WDATA;
        ImmSrc       = c_IMM_I;
        ALUControl   = c_ALU_ADD;
        Illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = c_SRCB_FOUR;
                ResultSrc = c_RES_ALURES;
                IRWrite   = w_mem_ready;
                PCWrite   = w_mem_ready;
                if (w_mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jal target into ALUOut.
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = (op == c_OP_JAL) ? c_IMM_J : c_IMM_B;
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE:            w_next_state = S_EXECR;
                    c_OP_ITYPE:            w_next_state = S_EXECI;
                    c_OP_BRANCH:           w_next_state = S_BRANCH;
                    c_OP_JAL:              w_next_state = S_JAL;
                    c_OP_JALR:             w_next_state = S_JALR1;
                    c_OP_LUI:              w_next_state = S_LUI;
                    c_OP_AUIPC:            w_next_state = S_AUIPC;
                    default:               w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = c_SRCA_REG;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = w_is_store ? c_IMM_S : c_IMM_I;
                if (func3 != 3'b010) begin
                    w_next_state = S_TRAP;
                end else if (w_is_store) begin
                    w_next_state = S_MEMWRITE;
                end else begin
                    w_next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (w_mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc    = c_RES_DATA;
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (w_mem_ready) begin
                    w_next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = c_SRCA_REG;
                ALUSrcB = c_SRCB_WDATA;
                if (w_r_legal) begin
                    ALUControl   = w_r_alu;
                    w_next_state = S_ALUWB;
                end else begin
                    w_next_state = S_TRAP;
                end
            end
            S_EXECI: begin
                ALUSrcA = c_SRCA_REG;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = c_IMM_I;
                if (w_func_legal) begin
                    ALUControl   = w_func_alu;
                    w_next_state = S_ALUWB;
                end else begin
                    w_next_state = S_TRAP;
                end
            end
            S_ALUWB: begin
                RegWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = c_SRCA_REG;
                ALUSrcB      = c_SRCB_WDATA;
                ALUControl   = c_ALU_SUB;
                PCWrite      = w_branch_taken;
                w_next_state = w_branch_legal ? S_FETCH : S_TRAP;
            end
            S_JAL: begin
                ALUSrcA      = c_SRCA_OLDPC;
                ALUSrcB      = c_SRCB_FOUR;
                PCWrite      = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA      = c_SRCA_REG;
                ALUSrcB      = c_SRCB_IMM;
                ImmSrc       = c_IMM_I;
                w_next_state = (func3 == 3'b000) ? S_JALR2 : S_TRAP;
            end
            S_JALR2: begin
                // Target bit 0 is deliberately left as computed.
                ALUSrcA      = c_SRCA_OLDPC;
                ALUSrcB      = c_SRCB_FOUR;
                PCWrite      = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB      = c_SRCB_IMM;
                ImmSrc       = c_IMM_U;
                ALUControl   = c_ALU_PASS;
                w_next_state = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA      = c_SRCA_OLDPC;
                ALUSrcB      = c_SRCB_IMM;
                ImmSrc       = c_IMM_U;
                w_next_state = S_ALUWB;
            end
            S_TRAP: begin
                Illegal = 1'b1;
            end
            default: begin
                w_next_state = S_TRAP;
            end
        endcase
        // No architectural write may escape during a reset cycle.
        if (reset) begin
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Randomized self-checking bench for mc_control_fsm
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR, P_EXECI,
        P_ALUWB, P_BRANCH, P_JAL, P_JALR1, P_JALR2, P_LUI, P_AUIPC, P_TRAP
    } ph_t;

    localparam int          c_MAX_CYCLES = 40000;
    localparam logic [17:0] c_EN_MASK    = 18'h3C001;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [6:0] op       = 7'd0;
    logic [2:0] func3    = 3'd0;
    logic       func7b5  = 1'b0;
    logic       Zero     = 1'b0;
    logic       Negative = 1'b0;
    logic       Carry    = 1'b0;
    logic       Overflow = 1'b0;
    logic       MemReady = 1'b0;
    logic       RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic [17:0] obs;

    ph_t        ph_q[$];
    int         n_total = 0;
    int         n_bad   = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset(reset), .op(op), .func3(func3), .func7b5(func7b5),
        .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .MemReady(MemReady), .RegWrite(RegWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    assign obs = {RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, Illegal};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h", tag, got, want);
        end
    endtask

    // Instruction-level reference: which steps an encoding walks through.
    task automatic plan(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bit alu_ok;
        alu_ok = (f3 != 3'b001) && (f3 != 3'b101);
        ph_q.delete();
        ph_q.push_back(P_FETCH);
        ph_q.push_back(P_DECODE);
        case (o)
            7'b0000011: begin
                ph_q.push_back(P_MEMADR);
                if (f3 == 3'b010) begin ph_q.push_back(P_MEMREAD); ph_q.push_back(P_MEMWB); end
                else ph_q.push_back(P_TRAP);
            end
            7'b0100011: begin
                ph_q.push_back(P_MEMADR);
                ph_q.push_back((f3 == 3'b010) ? P_MEMWRITE : P_TRAP);
            end
            7'b0110011: begin
                ph_q.push_back(P_EXECR);
                ph_q.push_back((alu_ok && (!f7 || f3 == 3'b000)) ? P_ALUWB : P_TRAP);
            end
            7'b0010011: begin
                ph_q.push_back(P_EXECI);
                ph_q.push_back(alu_ok ? P_ALUWB : P_TRAP);
            end
            7'b1100011: begin
                ph_q.push_back(P_BRANCH);
                if (f3 == 3'b010 || f3 == 3'b011) ph_q.push_back(P_TRAP);
            end
            7'b1101111: begin ph_q.push_back(P_JAL); ph_q.push_back(P_ALUWB); end
            7'b1100111: begin
                ph_q.push_back(P_JALR1);
                if (f3 == 3'b000) begin ph_q.push_back(P_JALR2); ph_q.push_back(P_ALUWB); end
                else ph_q.push_back(P_TRAP);
            end
            7'b0110111: begin ph_q.push_back(P_LUI); ph_q.push_back(P_ALUWB); end
            7'b0010111: begin ph_q.push_back(P_AUIPC); ph_q.push_back(P_ALUWB); end
            default:    ph_q.push_back(P_TRAP);
        endcase
    endtask

    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            3'b011:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // Branch outcome from the real operand comparison, not from the flags.
    function automatic logic exp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] model(input ph_t p, input logic mr, input logic [31:0] a,
                                          input logic [31:0] b);
        logic rw, irw, pcw, mw, adr, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu;
        {rw, irw, pcw, mw, adr, ill} = 6'd0;
        {rs, sa, sb} = 6'd0;
        imm = 3'd0;
        alu = 3'd0;
        case (p)
            P_FETCH:    begin sb = 2; rs = 2; irw = mr; pcw = mr; end
            P_DECODE:   begin sa = 1; sb = 1; imm = (op == 7'b1101111) ? 3'b011 : 3'b010; end
            P_MEMADR:   begin sa = 2; sb = 1; imm = (op == 7'b0100011) ? 3'b001 : 3'b000; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 1; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXECR:    begin sa = 2; alu = exp_alu(func3, func7b5); end
            P_EXECI:    begin sa = 2; sb = 1; alu = exp_alu(func3, 1'b0); end
            P_ALUWB:    rw = 1;
            P_BRANCH:   begin sa = 2; alu = 3'b001; pcw = exp_taken(func3, a, b); end
            P_JAL:      begin sa = 1; sb = 2; pcw = 1; end
            P_JALR1:    begin sa = 2; sb = 1; end
            P_JALR2:    begin sa = 1; sb = 2; pcw = 1; end
            P_LUI:      begin sb = 1; imm = 3'b100; alu = 3'b111; end
            P_AUIPC:    begin sa = 1; sb = 1; imm = 3'b100; end
            default:    ill = 1;
        endcase
        return {rw, irw, pcw, mw, adr, rs, sa, sb, imm, alu, ill};
    endfunction

    // Called at posedge+1; returns at the next posedge+1.
    task automatic do_cycle(input ph_t p, input logic mr, input logic rst_now, input bit alu_dc,
                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic [17:0] m;
        d        = a - b;
        MemReady = mr;
        reset    = rst_now;
        Zero     = (a == b);
        Negative = d[31];
        Carry    = (a >= b);
        Overflow = (a[31] != b[31]) && (d[31] != a[31]);
        #3;
        if (rst_now) begin
            chk({"reset_en@", p.name()}, 32'(obs & c_EN_MASK), 32'd0);
        end else begin
            m = alu_dc ? 18'h3FFF1 : 18'h3FFFF;
            chk(p.name(), 32'(obs & m), 32'(model(p, mr, a, b) & m));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] instr, input int fetch_st, input int mem_st,
                             input bit rnd_mr, input bit rnd_ops, input logic [31:0] a0,
                             input logic [31:0] b0, input int rst_idx);
        ph_t p;
        logic [31:0] a, b;
        logic mr;
        int k;
        bit dc;
        op      = instr[6:0];
        func3   = instr[14:12];
        func7b5 = instr[30];
        plan(op, func3, func7b5);
        for (int i = 0; i < ph_q.size(); i++) begin
            p = ph_q[i];
            dc = (p == P_EXECR || p == P_EXECI) && (i + 1 < ph_q.size()) && (ph_q[i+1] == P_TRAP);
            k = 0;
            forever begin
                a = rnd_ops ? $urandom : a0;
                b = rnd_ops ? (($urandom_range(0, 3) == 0) ? a : $urandom) : b0;
                if (i == rst_idx) begin
                    do_cycle(p, 1'($urandom_range(0, 1)), 1'b1, 1'b0, a, b);
                    return;
                end
                if (p == P_TRAP) begin
                    repeat (4) do_cycle(p, 1'($urandom_range(0, 1)), 1'b0, 1'b0, a, b);
                    do_cycle(p, 1'b1, 1'b1, 1'b0, a, b);
                    return;
                end
                if (p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE) begin
                    if (rnd_mr) mr = (k >= 6) || ($urandom_range(0, 2) != 0);
                    else        mr = (k >= ((p == P_FETCH) ? fetch_st : mem_st));
                end else begin
                    mr = 1'($urandom_range(0, 1));
                end
                do_cycle(p, mr, 1'b0, dc, a, b);
                k++;
                if (mr || !(p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE)) break;
            end
        end
    endtask

    initial begin
        #(c_MAX_CYCLES * 10);
        $display("FAIL watchdog: got no finish expected finish within %0d cycles", c_MAX_CYCLES);
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] op_pool[9];
        logic [31:0] ins;
        logic [6:0] o;
        op_pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        @(posedge clk);
        #1;
        repeat (2) do_cycle(P_FETCH, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);

        run_instr(32'h00012083, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // lw
        run_instr(32'h0020A223, 0, 3, 0, 0, 32'd0, 32'd0, -1);                 // sw, 3 waits
        run_instr(32'h00208463, 0, 0, 0, 0, 32'd5, 32'd5, -1);                 // beq taken
        run_instr(32'h00208463, 0, 0, 0, 0, 32'd5, 32'd6, -1);                 // beq not taken
        run_instr(32'h0020C463, 0, 0, 0, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, -1);   // blt N=V=1
        run_instr(32'h008000EF, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // jal
        run_instr(32'h002081B3, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // add
        run_instr(32'h402081B3, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // sub
        run_instr(32'h002091B3, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // sll -> trap
        run_instr(32'h00108093, 5, 0, 0, 0, 32'd0, 32'd0, -1);                 // addi, fetch waits
        run_instr(32'h00012083, 0, 2, 0, 0, 32'd0, 32'd0, 3);                  // reset in MEMREAD
        run_instr(32'h0020A223, 0, 2, 0, 0, 32'd0, 32'd0, 3);                  // reset in MEMWRITE
        run_instr(32'h000080E7, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // jalr
        run_instr(32'h123450B7, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // lui
        run_instr(32'h00001097, 0, 0, 0, 0, 32'd0, 32'd0, -1);                 // auipc

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            o   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_pool[$urandom_range(0, 8)];
            ins[6:0] = o;
            if ($urandom_range(0, 3) != 0) begin
                if (o == 7'b0000011 || o == 7'b0100011) ins[14:12] = 3'b010;
                else if (o == 7'b1100111) ins[14:12] = 3'b000;
                else if (o == 7'b0110011 && $urandom_range(0, 1) == 1) ins[30] = 1'b0;
            end
            run_instr(ins, 0, 0, 1, 1, 32'd0, 32'd0,
                      ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main sequencing FSM for the RV32 multicycle datapath. Decodes op/func3/func7b5 from the instruction register and drives every datapath enable and mux select once per clock. It also handles the external-memory wait handshake and branch resolution from the ALU flags. Unsupported encodings park the core in a trap state.

Parameters:
MEM_WAIT_EN, 1, when 0 MemReady is ignored and treated as constant 1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high; forces state to FETCH
op  input  7  InstrReg[6:0]
func3  input  3  InstrReg[14:12]
func7b5  input  1  InstrReg[30]
Zero, Negative, Carry, Overflow  input  1 each  ALU flags, combinational from current SrcA/SrcB
MemReady  input  1  external memory completes the current access this cycle
RegWrite, IRWrite, PCWrite, MemWrite, AdrSrc  output  1 each  datapath controls
ResultSrc, ALUSrcA, ALUSrcB  output  2 each  mux selects (A: 0 PC, 1 OldPC, 2 A; B: 0 WriteData, 1 ImmExt, 2 const 4; Result: 0 ALUOut, 1 Data, 2 ALUResult)
ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu, 111 pass SrcB
Illegal  output  1  high while in TRAP

Behaviour:
- Outputs are Moore-decoded from state. There are two exceptions: FETCH enables are gated by MemReady, and the BRANCH PCWrite is gated by the flags. Unlisted outputs are 0.
- Reset cycle: state becomes FETCH. RegWrite, IRWrite, PCWrite and MemWrite are forced to 0 while reset=1. Illegal=0.
- FETCH: AdrSrc=0, A=0, B=2, add, ResultSrc=2. IRWrite=PCWrite=MemReady. Stay until MemReady, then go to DECODE.
- DECODE: A=1, B=1, add. ImmSrc=J if op=1101111, else B. The branch/jal target lands in ALUOut.
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR1; 0110111 -> LUI; 0010111 -> AUIPC; anything else -> TRAP.
- MEMADR: A=2, B=1, add. ImmSrc=I for loads, S for stores. Requires func3=010, else TRAP. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=0. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=1, RegWrite=1. Then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=0. MemWrite=1 continuously until the cycle MemReady=1, then FETCH.
- EXECR: A=2, B=0. Then ALUWB.
  - func3 000 gives add (func7b5=0) or sub (func7b5=1).
  - 111 and, 110 or, 100 xor, 010 slt, 011 sltu.
  - func7b5=1 with any func3 other than 000, or any other func3 (shifts), goes to TRAP.
- EXECI: A=2, B=1, ImmSrc=I. Same func3 map, always add for 000, func7b5 ignored. Shifts go to TRAP. Then ALUWB.
- ALUWB: ResultSrc=0, RegWrite=1. Then FETCH.
- BRANCH: A=2, B=0, sub, ResultSrc=0. Then FETCH.
  - PCWrite condition by func3: 000 Zero; 001 !Zero; 100 Negative^Overflow; 101 !(Negative^Overflow); 110 !Carry; 111 Carry.
  - Carry=1 means no borrow. func3 010/011 go to TRAP with PCWrite=0.
- JAL: A=1, B=2, add, ResultSrc=0, PCWrite=1. Then ALUWB (rd = OldPC+4).
- JALR1: requires func3=000, else TRAP. A=2, B=1, ImmSrc=I, add. Then JALR2.
- JALR2: A=1, B=2, add, ResultSrc=0, PCWrite=1. Then ALUWB. Target bit 0 is not cleared.
- LUI: B=1, ImmSrc=U, pass SrcB. Then ALUWB.
- AUIPC: A=1, B=1, ImmSrc=U, add. Then ALUWB.
- TRAP: all enables 0, Illegal=1. Held until reset.
- Zero-wait cycle counts:
  - lw 5; sw 4.
  - R, I, jal, lui, auipc 4.
  - jalr 5; branch 3.
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: next state is FETCH with no write enable asserted, including mid-MEMWRITE.

Test Plan:
- reset=1 for 2 cycles, then lw 0x00012083 (x1 ← mem[x2+0]) with MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5, ResultSrc=1, Illegal=0.
- sw 0x0020A223 with MemReady low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles with AdrSrc=1, then FETCH. PCWrite=0 throughout MEMWRITE.
- beq 0x00208463 with Zero=1 and then with Zero=0 -> PCWrite=1 in BRANCH only for Zero=1. blt with Negative=1, Overflow=1 -> PCWrite=0.
- jal 0x008000EF -> ImmSrc=011 in DECODE, PCWrite=1 in JAL, then RegWrite=1 with ResultSrc=0. Total 4 cycles.
- R-type add 0x002081B3 -> ALUControl=000. sub 0x402081B3 -> 001. sll 0x002091B3 -> TRAP, Illegal=1, sticky until reset.
- FETCH with MemReady=0 for 5 cycles -> IRWrite=PCWrite=0 throughout. reset asserted mid-MEMREAD -> FETCH next cycle, RegWrite never asserted.
